// File: rtl/queen_pkg.sv
// queen_pkg: shared board size, index/state types and row-vector packing width for the queen sequencer.
package queen_pkg;
   localparam int N_BOARD = 12;
   localparam int ROW_W = 4 * N_BOARD;
   typedef logic [3:0] col_t;
   typedef logic [3:0] row_t;
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_START = 3'd2;
   localparam state_t ST_WAIT  = 3'd3;
   localparam state_t ST_OUT   = 3'd4;
endpackage

// File: rtl/queen_out_ser.sv
// queen_out_ser: loads a packed N-column result and emits one 4-bit row per cycle, column 0 first.
module queen_out_ser #(
   parameter int N = 12
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_i,
   input  logic [4*N-1:0] data_i,
   output logic           out_valid_o,
   output logic [3:0]     out_o,
   output logic           last_o
);
   logic [4*N-1:0] sh_q;
   logic [3:0]     cnt_q;
   logic           vld_q;
   assign last_o      = vld_q && (cnt_q == 4'(N - 1));
   assign out_valid_o = vld_q;
   assign out_o       = vld_q ? sh_q[3:0] : 4'h0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
         vld_q <= 1'b0;
      end else if (load_i) begin
         sh_q  <= data_i;
         cnt_q <= '0;
         vld_q <= 1'b1;
      end else if (vld_q) begin
         sh_q  <= {4'h0, sh_q[4*N-1:4]};
         cnt_q <= cnt_q + 4'd1;
         vld_q <= !last_o;
      end
   end
endmodule

// File: rtl/queen_seq_ctrl.sv
// queen_seq_ctrl: collects pre-placed queens, launches the solver and streams its solution column by column.
// Optional watchdog in WAIT enabled by defining QUEEN_TMO_EN.
module queen_seq_ctrl
   import queen_pkg::*;
#(
   parameter int N       = N_BOARD,
   parameter int TMO_CYC = 4096
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid_num,
   input  logic [2:0]     in_num,
   input  logic           in_valid,
   input  col_t           col,
   input  row_t           row,
   output logic           slv_start,
   output logic [N-1:0]   slv_fix_mask,
   output logic [4*N-1:0] slv_fix_row,
   input  logic           slv_done,
   input  logic [4*N-1:0] slv_sol_row,
   output logic           out_valid,
   output logic [3:0]     out
);
   state_t         state_q, state_d;
   logic [2:0]     num_q, num_d, cnt_q, cnt_d;
   logic [N-1:0]   mask_q, mask_d;
   logic [4*N-1:0] fix_q, fix_d;
   logic           tmo_hit, ser_load, ser_last;
`ifdef QUEEN_TMO_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tmo_q;
   assign tmo_hit = (state_q == ST_WAIT) && !slv_done && (tmo_q == TW'(TMO_CYC - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_q <= '0;
      else tmo_q <= (state_q == ST_WAIT) ? tmo_q + 1'b1 : '0;
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^TMO_CYC;
   assign tmo_hit = 1'b0;
`endif
   // a timeout reports an all-15 board so downstream can tell it from any legal solution
   assign ser_load     = (state_q == ST_WAIT) && (slv_done || tmo_hit);
   assign slv_start    = (state_q == ST_START);
   assign slv_fix_mask = mask_q;
   assign slv_fix_row  = fix_q;
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      fix_d   = fix_q;
      case (state_q)
         ST_IDLE: if (in_valid_num) begin
            num_d   = in_num;
            cnt_d   = '0;
            mask_d  = '0;
            fix_d   = '0;
            state_d = (in_num == 3'd0) ? ST_START : ST_LOAD;
         end
         ST_LOAD: if (in_valid) begin
            cnt_d = cnt_q + 3'd1;
            for (int c = 0; c < N; c++)
               if (col == col_t'(c)) begin
                  mask_d[c]       = 1'b1;
                  fix_d[4*c +: 4] = row;
               end
            if (cnt_q + 3'd1 == num_q) state_d = ST_START;
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  state_d = ser_load ? ST_OUT : ST_WAIT;
         ST_OUT:   state_d = ser_last ? ST_IDLE : ST_OUT;
         default:  state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         num_q   <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         fix_q   <= '0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         fix_q   <= fix_d;
      end
   end
   queen_out_ser #(.N(N)) u_ser (
      .clk         (clk),
      .rst         (rst),
      .load_i      (ser_load),
      .data_i      (slv_done ? slv_sol_row : {4*N{1'b1}}),
      .out_valid_o (out_valid),
      .out_o       (out),
      .last_o      (ser_last)
   );
endmodule

// File: doc/queen_seq_ctrl.md
QUEEN_SEQ_CTRL -- requirements
Module: queen_seq_ctrl

Interface
REQ-001 Parameter: N, 12, board size in columns/rows (4-bit indices, max 15).
REQ-002 Parameter: TMO_CYC, 4096, watchdog limit in WAIT state (used only with QUEEN_TMO_EN).
REQ-003 Port: clk  in  1  single clock; all flops rising-edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: in_valid_num  in  1  one-cycle pulse qualifying in_num.
REQ-006 Port: in_num  in  3  count of pre-placed queens (0..7).
REQ-007 Port: in_valid  in  1  qualifies one col/row pair per cycle.
REQ-008 Port: col  in  4  column of pre-placed queen.
REQ-009 Port: row  in  4  row of pre-placed queen.
REQ-010 Port: slv_start  out  1  one-cycle start pulse to solver datapath.
REQ-011 Port: slv_fix_mask  out  N  bit c set = column c pre-placed.
REQ-012 Port: slv_fix_row  out  4*N  row of pre-placed queen per column, column c at [4c+3:4c].
REQ-013 Port: slv_done  in  1  one-cycle pulse, solution valid on slv_sol_row.
REQ-014 Port: slv_sol_row  in  4*N  solved row per column, same packing as slv_fix_row.
REQ-015 Port: out_valid  out  1  high for exactly N consecutive result cycles.
REQ-016 Port: out  out  4  row of queen in current column; 0 when out_valid low.

Function
REQ-017 FSM states IDLE, LOAD, START, WAIT, OUT; all transitions on clk edge.
REQ-018 IDLE: in_valid_num high captures in_num, clears mask/row table; in_num=0 -> START, else -> LOAD.
REQ-019 LOAD: each in_valid cycle stores row into column col, sets mask bit, increments pair counter; after the in_num-th pair -> START next cycle.
REQ-020 Pair with col >= N: not stored, still counted.
REQ-021 Duplicate col: later row overwrites earlier; still counted.
REQ-022 START: slv_start high exactly one cycle; slv_fix_mask/slv_fix_row stable from START until leaving WAIT; -> WAIT.
REQ-023 WAIT: slv_done latches slv_sol_row into result register -> OUT; latency slv_done to first out_valid = 1 cycle.
REQ-024 OUT: out_valid high N cycles, out = result row for column 0, 1, ..., N-1 in order; then -> IDLE with out_valid low next cycle.
REQ-025 in_valid outside LOAD, in_valid_num outside IDLE, slv_done outside WAIT: ignored, no state change.
REQ-026 in_valid_num and in_valid both high in IDLE: pair ignored, only in_num captured.
REQ-027 Back-to-back: in_valid_num accepted in the first IDLE cycle after OUT.

Reset
REQ-028 rst asserted: immediate return to IDLE from any state, including mid-LOAD/WAIT/OUT.
REQ-029 Reset values: out_valid=0, out=0, slv_start=0, slv_fix_mask=0, slv_fix_row=0, counters and result register 0.

Configuration
REQ-030 Macro QUEEN_TMO_EN defined: WAIT counter; after TMO_CYC cycles without slv_done -> OUT with result all 4'hF (out=15 for N cycles).
REQ-031 Macro QUEEN_TMO_EN undefined: no counter, WAIT holds indefinitely until slv_done; TMO_CYC unused.

Structure
REQ-032 Shared package queen_pkg holds N_BOARD=12, state enum type, col_t/row_t 4-bit typedefs, row-vector packing width constant.
REQ-033 One sub-module queen_out_ser: loads N×4 result, shifts one column per cycle onto out/out_valid.

Verification
REQ-034 in_num=2, pairs (0,3),(5,7) -> slv_fix_mask=12'h021, slv_fix_row[3:0]=3, [23:20]=7, single slv_start pulse 1 cycle after 2nd pair.
REQ-035 slv_done with solution 0,2,4,6,8,10,1,3,5,7,9,11 -> out_valid 12 cycles starting next cycle, out sequence identical, then out=0.
REQ-036 in_num=0 -> slv_start 1 cycle after in_valid_num, slv_fix_mask=0.
REQ-037 in_num=3 pairs (4,1),(13,2),(4,9) -> mask bit 4 only, row[19:16]=9, START after 3rd pair.
REQ-038 rst pulsed during OUT cycle 5 -> out_valid=0, out=0 immediately; new job accepted afterwards.
REQ-039 QUEEN_TMO_EN with TMO_CYC=16, no slv_done -> 12 cycles out=4'hF; without macro, out_valid stays 0 for 10000 cycles.
